seqdet_param: RTL and testbench

- Parametrised serial pattern detector; next generation of the fixed-pattern 3-bit-state detector.
- Pattern, pattern length and overlap mode are runtime-programmable. Input is qualified by a valid strobe.
- Sits between the serial input pin logic and the indicator/status outputs of the tile; one bit is evaluated per valid cycle.

---
 rtl/seqdet_pkg.sv | 13 +
 rtl/seqdet_shreg.sv | 25 ++
 rtl/seqdet_param.sv | 114 +++++++++++
 tb/tb_seqdet_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// FSM state encoding and the default maximum pattern length.
package seqdet_pkg;

   localparam int DEF_PAT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

endpackage

// File: rtl/seqdet_shreg.sv
// Serial-in shift register with valid enable, synchronous clear and
// asynchronous active-low reset; newest bit enters at bit 0.
module seqdet_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic         din,
   output logic [W-1:0] q
);

   // clear has priority over enable, so a bit presented with clear is dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (enable) begin
         q <= {q[W-2:0], din};
      end
   end

endmodule

// File: rtl/seqdet_param.sv
// Runtime-programmable serial pattern detector (pattern, length, overlap).
// Optional saturating match counter enabled by SEQDET_MATCH_COUNT_EN.
module seqdet_param
   import seqdet_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             input_valid,
   input  logic             input_bit,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap_en,
   output logic             output_indicator,
   output logic [1:0]       present_state
`ifdef SEQDET_MATCH_COUNT_EN
   ,
   output logic [7:0]       match_count
`endif
);

   // input_valid is a one-way strobe with no back-pressure: every cycle it is
   // high, input_bit is consumed, unless clear is also high (bit discarded).

   state_t           state, state_next;
   logic [PAT_W-1:0] hist, hist_next, mask;
   logic [LEN_W-1:0] fill, fill_next, fill_eff, len_m1;
   logic             len_ok, accept, window_hit, match;
   logic             hist_msb_unused;

   seqdet_shreg #(.W(PAT_W)) u_hist (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .enable (input_valid),
      .din    (input_bit),
      .q      (hist)
   );

   // The oldest history bit shifts out before any window can reach it.
   assign hist_msb_unused = hist[PAT_W-1];
   assign hist_next       = {hist[PAT_W-2:0], input_bit};

   assign accept = input_valid && !clear;
   assign len_ok = (pat_len != '0) && (int'(pat_len) <= PAT_W);
   assign len_m1 = pat_len - LEN_W'(1);

   // A length change can leave fill above the new window; clamp before use.
   assign fill_eff = (fill > len_m1) ? len_m1 : fill;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(pat_len));
      end
   end

   // State register: FSM state, fill count and the registered match pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         fill             <= '0;
         output_indicator <= 1'b0;
      end else begin
         state            <= state_next;
         fill             <= fill_next;
         output_indicator <= match;
      end
   end

   // Next-state logic: only accepted bits move the FSM and the fill count.
   always_comb begin
      state_next = state;
      fill_next  = fill;
      if (clear) begin
         state_next = ST_IDLE;
         fill_next  = '0;
      end else if (input_valid) begin
         if (!len_ok) begin
            state_next = ST_IDLE;
            fill_next  = '0;
         end else if (match && !overlap_en) begin
            state_next = ST_IDLE;
            fill_next  = '0;
         end else begin
            fill_next  = fill_eff + LEN_W'(1);
            state_next = (fill_next >= len_m1) ? ST_ARMED : ST_FILL;
         end
      end
   end

   // Output logic: the completing bit is judged against the post-shift window.
   always_comb begin
      window_hit    = (((hist_next ^ pattern) & mask) == '0);
      match         = accept && len_ok && (fill_eff == len_m1) && window_hit;
      present_state = state;
   end

`ifdef SEQDET_MATCH_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match_count <= '0;
      end else if (clear) begin
         match_count <= '0;
      end else if (match && (match_count != 8'hFF)) begin
         match_count <= match_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seqdet_param.sv
// Directed bench for seqdet_param: queue-based reference model checked every
// cycle, plus literal pulse positions per scenario. Honours SEQDET_MATCH_COUNT_EN.
module tb_seqdet_param;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             input_valid;
   logic             input_bit;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;
   logic             overlap_en;
   logic             output_indicator;
   logic [1:0]       present_state;
`ifdef SEQDET_MATCH_COUNT_EN
   logic [7:0]       match_count;
`endif

   int total = 0;
   int bad   = 0;

   seqdet_param #(.PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
      .clk              (clk),
      .reset            (rst_n),
      .clear            (clear),
      .input_valid      (input_valid),
      .input_bit        (input_bit),
      .pattern          (pattern),
      .pat_len          (pat_len),
      .overlap_en       (overlap_en),
      .output_indicator (output_indicator),
      .present_state    (present_state)
`ifdef SEQDET_MATCH_COUNT_EN
      ,
      .match_count      (match_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // reference model: keeps the accepted bit stream and the bits since restart
   bit          mhist[$];
   int          since   = 0;
   logic [7:0]  mcnt    = '0;
   logic [1:0]  mstate  = '0;
   logic        mind    = 1'b0;
   int          acc_idx = 0;
   int          edge_idx = 0;
   logic [10:0] exp_q[$];
   logic [10:0] cur_exp = '0;
   int          pulses[$];

   always @(posedge clk or negedge rst_n) begin
      bit hit;
      if (!rst_n) begin
         mhist.delete();
         since = 0; mcnt = '0; mstate = 2'd0; mind = 1'b0; edge_idx = 0;
      end else begin
         mind = 1'b0;
         edge_idx = 0;
         if (clear) begin
            mhist.delete();
            since = 0; mcnt = '0; mstate = 2'd0;
         end else if (input_valid) begin
            acc_idx++;
            edge_idx = acc_idx;
            mhist.push_back(input_bit);
            if (mhist.size() > 16) void'(mhist.pop_front());
            if (pat_len == 0 || int'(pat_len) > PAT_W) begin
               since  = 0;
               mstate = 2'd0;
            end else begin
               hit = (since + 1 >= int'(pat_len)) && (mhist.size() >= int'(pat_len));
               for (int k = 0; k < int'(pat_len); k++)
                  if (hit && (mhist[mhist.size() - 1 - k] != pattern[k])) hit = 0;
               if (hit) begin
                  mind = 1'b1;
                  if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
               end
               if (hit && !overlap_en) since = 0;
               else since++;
               if (since == 0) mstate = 2'd0;
               else if (since >= int'(pat_len) - 1) mstate = 2'd2;
               else mstate = 2'd1;
            end
         end
      end
      exp_q.push_back({mcnt, mstate, mind});
   end

   // scoreboard: compare on the falling edge against the latest expectation
   always @(negedge clk) begin
      while (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      check("indicator", int'(output_indicator), int'(cur_exp[0]));
      check("state", int'(present_state), int'(cur_exp[2:1]));
`ifdef SEQDET_MATCH_COUNT_EN
      check("match_count", int'(match_count), int'(cur_exp[10:3]));
`endif
      if (output_indicator) pulses.push_back(edge_idx);
   end

   // driver tasks
   task automatic drive(input logic v, input logic b, input logic c);
      @(negedge clk);
      input_valid = v;
      input_bit   = b;
      clear       = c;
   endtask

   task automatic flush();
      repeat (3) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic start_scen(input logic [PAT_W-1:0] p, input int l, input logic o);
      @(negedge clk);
      pattern     = p;
      pat_len     = LEN_W'(l);
      overlap_en  = o;
      clear       = 1'b1;
      input_valid = 1'b0;
      acc_idx     = 0;
      pulses.delete();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         repeat (gap) drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic bit_chk(input logic b, input int want_state, input string name);
      @(negedge clk);
      check(name, int'(present_state), want_state);
      input_valid = 1'b1;
      input_bit   = b;
      clear       = 1'b0;
   endtask

   task automatic check_pulses(input string name, input int n, input int a, input int b, input int c);
      int want[3];
      want = '{a, b, c};
      check({name, "_count"}, pulses.size(), n);
      for (int i = 0; i < n && i < 3 && i < pulses.size(); i++)
         check({name, "_pos"}, pulses[i], want[i]);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; input_valid = 1'b0; input_bit = 1'b0;
      pattern = 8'b0000_1011; pat_len = 4'd4; overlap_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_ind", int'(output_indicator), 0);
      check("reset_state", int'(present_state), 0);
      rst_n = 1'b1;

      // 1: overlapping, pulses after bits 4, 7, 10; ARMED after bit 3
      start_scen(8'b0000_1011, 4, 1'b1);
      send_bits(16'b101, 3, 0);
      bit_chk(1'b1, 2, "s1_armed");
      send_bits(16'b011011, 6, 0);
      flush();
      check_pulses("s1", 3, 4, 7, 10);

      // 2: non-overlapping, pulses after bits 4 and 10; IDLE right after match
      start_scen(8'b0000_1011, 4, 1'b0);
      send_bits(16'b1011, 4, 0);
      bit_chk(1'b0, 0, "s2_idle");
      send_bits(16'b11011, 5, 0);
      flush();
      check_pulses("s2", 2, 4, 10, 0);

      // 3: three idle cycles after every valid bit
      start_scen(8'b0000_1011, 4, 1'b1);
      send_bits(16'b10_1101_1011, 10, 3);
      flush();
      check_pulses("s3", 3, 4, 7, 10);

      // 4: clear with a valid bit discards it and the earlier history
      start_scen(8'b0000_1011, 4, 1'b1);
      send_bits(16'b10, 2, 0);
      drive(1'b1, 1'b1, 1'b1);
      send_bits(16'b1011, 4, 0);
      flush();
      check_pulses("s4", 1, 6, 0, 0);

      // 5: asynchronous reset mid-pattern, then the completing bit
      start_scen(8'b0000_1011, 4, 1'b1);
      send_bits(16'b101, 3, 0);
      @(negedge clk);
      input_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_ind", int'(output_indicator), 0);
      check("s5_rst_state", int'(present_state), 0);
`ifdef SEQDET_MATCH_COUNT_EN
      check("s5_rst_cnt", int'(match_count), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("s5_state_fill", int'(present_state), 1);
      input_valid = 1'b0;
      flush();
      check_pulses("s5", 0, 0, 0, 0);

      // 6: pattern 11, length 2, 300 ones; then an illegal length
      start_scen(8'b0000_0011, 2, 1'b1);
      repeat (300) drive(1'b1, 1'b1, 1'b0);
      flush();
      check_pulses("s6", 299, 2, 3, 4);
`ifdef SEQDET_MATCH_COUNT_EN
      check("s6_sat", int'(match_count), 255);
`endif
      @(negedge clk);
      pat_len = 4'd0;
      repeat (5) drive(1'b1, 1'b1, 1'b0);
      flush();
      check("s6_len0_pulses", pulses.size(), 299);
      check("s6_len0_state", int'(present_state), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
